// File: rtl/ren_chain_pipe.sv
// ren_chain_pipe: a read-enable plus tag carried through STAGES registered
// stages. The chain can stall, be flushed, and reports per-stage valid bits,
// an occupancy count and an OR/AND reduction of all stage valids.
//
// Flow control: io_advance is a plain shift enable, not a valid/ready
// handshake. On a rising edge with io_advance=1 every stage takes the
// contents of the stage before it, and stage 0 takes io_in_ren/io_in_tag.
// Whatever sat in the last stage is dropped. There is no backpressure.
// io_flush overrides io_advance and clears every stage on that edge.
module ren_chain_pipe #(
    parameter int STAGES = 4,
    parameter int TAG_W  = 8,
    localparam int OCC_W = $clog2(STAGES + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              io_in_ren,
    input  logic [TAG_W-1:0]  io_in_tag,
    input  logic              io_advance,
    input  logic              io_flush,
    input  logic              io_mode,
    output logic              io_out_ren,
    output logic [TAG_W-1:0]  io_out_tag,
    output logic [STAGES-1:0] io_stage_valid,
    output logic [OCC_W-1:0]  io_occupancy,
    output logic              io_result
);

    logic [STAGES-1:0] v_q;
    logic [TAG_W-1:0]  t_q [STAGES];
    logic [OCC_W-1:0]  occ;

    // Valid chain: flush clears, advance shifts, otherwise hold.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v_q <= '0;
        end else if (io_flush) begin
            v_q <= '0;
        end else if (io_advance) begin
            v_q[0] <= io_in_ren;
            for (int i = 1; i < STAGES; i++) begin
                v_q[i] <= v_q[i-1];
            end
        end
    end

    // Tag chain: shifts alongside the valids, captured even when ren is 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < STAGES; i++) begin
                t_q[i] <= '0;
            end
        end else if (io_flush) begin
            for (int i = 0; i < STAGES; i++) begin
                t_q[i] <= '0;
            end
        end else if (io_advance) begin
            t_q[0] <= io_in_tag;
            for (int i = 1; i < STAGES; i++) begin
                t_q[i] <= t_q[i-1];
            end
        end
    end

    // Occupancy is the population count of the stage valids.
    always_comb begin
        occ = '0;
        for (int i = 0; i < STAGES; i++) begin
            occ = occ + OCC_W'(v_q[i]);
        end
    end

    assign io_out_ren     = v_q[STAGES-1];
    assign io_out_tag     = t_q[STAGES-1];
    assign io_stage_valid = v_q;
    assign io_occupancy   = occ;
    // io_mode is the only input allowed to reach an output combinationally.
    assign io_result      = io_mode ? (&v_q) : (|v_q);

endmodule

// File: tb/tb_ren_chain_pipe.sv
// Directed bench for ren_chain_pipe: a default 4-stage instance plus
// 1-stage/1-bit and 16-stage/32-bit instances sharing the same stimulus.
module tb_ren_chain_pipe;

    logic        clk;
    logic        reset;
    logic        in_ren;
    logic [31:0] in_tag;
    logic        advance;
    logic        flush;
    logic        mode;

    logic        out_ren4;
    logic [7:0]  out_tag4;
    logic [3:0]  sv4;
    logic [2:0]  occ4;
    logic        res4;

    logic        out_ren1;
    logic [0:0]  out_tag1;
    logic [0:0]  sv1;
    logic [0:0]  occ1;
    logic        res1;

    logic        out_ren16;
    logic [31:0] out_tag16;
    logic [15:0] sv16;
    logic [4:0]  occ16;
    logic        res16;

    int errors = 0;
    int checks = 0;

    ren_chain_pipe #(.STAGES(4), .TAG_W(8)) dut4 (
        .clk(clk), .reset(reset), .io_in_ren(in_ren), .io_in_tag(in_tag[7:0]),
        .io_advance(advance), .io_flush(flush), .io_mode(mode),
        .io_out_ren(out_ren4), .io_out_tag(out_tag4), .io_stage_valid(sv4),
        .io_occupancy(occ4), .io_result(res4)
    );

    ren_chain_pipe #(.STAGES(1), .TAG_W(1)) dut1 (
        .clk(clk), .reset(reset), .io_in_ren(in_ren), .io_in_tag(in_tag[0:0]),
        .io_advance(advance), .io_flush(flush), .io_mode(mode),
        .io_out_ren(out_ren1), .io_out_tag(out_tag1), .io_stage_valid(sv1),
        .io_occupancy(occ1), .io_result(res1)
    );

    ren_chain_pipe #(.STAGES(16), .TAG_W(32)) dut16 (
        .clk(clk), .reset(reset), .io_in_ren(in_ren), .io_in_tag(in_tag),
        .io_advance(advance), .io_flush(flush), .io_mode(mode),
        .io_out_ren(out_ren16), .io_out_tag(out_tag16), .io_stage_valid(sv16),
        .io_occupancy(occ16), .io_result(res16)
    );

    // Clock: 10 time-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One rising edge, then settle 1 unit so outputs are sampled off the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic adv(input logic ren, input logic [31:0] tag);
        in_ren  = ren;
        in_tag  = tag;
        advance = 1'b1;
        flush   = 1'b0;
        step();
    endtask

    task automatic do_flush();
        advance = 1'b0;
        flush   = 1'b1;
        step();
        flush   = 1'b0;
    endtask

    task automatic test_reset();
        // Outputs while reset is held from time zero.
        checks++;
        if ({out_ren4, out_tag4, sv4, occ4, res4} !== 17'd0) begin
            errors++;
            $display("FAIL reset_hold: got ren=%b tag=%h sv=%b occ=%0d res=%b, want all 0",
                     out_ren4, out_tag4, sv4, occ4, res4);
        end
        @(negedge clk);
        reset = 1'b0;
        // Fill all four stages, then assert reset between edges.
        for (int i = 0; i < 4; i++) adv(1'b1, 32'h10 + i);
        checks++;
        if (sv4 !== 4'b1111 || occ4 !== 3'd4 || out_tag4 !== 8'h10) begin
            errors++;
            $display("FAIL reset_prefill: got sv=%b occ=%0d tag=%h, want 1111 4 10", sv4, occ4, out_tag4);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (sv4 !== 4'b0000 || occ4 !== 3'd0 || res4 !== 1'b0 || out_ren4 !== 1'b0 || out_tag4 !== 8'h00) begin
            errors++;
            $display("FAIL reset_async: got sv=%b occ=%0d res=%b ren=%b tag=%h, want 0000 0 0 0 00",
                     sv4, occ4, res4, out_ren4, out_tag4);
        end
        mode = 1'b1;
        #1;
        checks++;
        if (res4 !== 1'b0) begin
            errors++;
            $display("FAIL reset_and_mode: got res=%b, want 0", res4);
        end
        mode = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        advance = 1'b0;
    endtask

    task automatic test_latency();
        logic [3:0] exp_sv;
        do_flush();
        mode = 1'b0;
        adv(1'b1, 32'h5A);
        for (int k = 0; k < 4; k++) begin
            exp_sv = 4'b0001 << k;
            checks++;
            if (sv4 !== exp_sv || res4 !== 1'b1 || out_ren4 !== (k == 3)) begin
                errors++;
                $display("FAIL latency_edge%0d: got sv=%b res=%b out_ren=%b, want sv=%b res=1 out_ren=%b",
                         k, sv4, res4, out_ren4, exp_sv, (k == 3));
            end
            if (k == 3) begin
                checks++;
                if (out_tag4 !== 8'h5A) begin
                    errors++;
                    $display("FAIL latency_tag: got %h, want 5a", out_tag4);
                end
            end
            if (k < 3) adv(1'b0, 32'h0);
        end
        adv(1'b0, 32'h0);
        checks++;
        if (sv4 !== 4'b0000 || res4 !== 1'b0) begin
            errors++;
            $display("FAIL latency_drain: got sv=%b res=%b, want 0000 0", sv4, res4);
        end
        // A tag rides through even when its ren is 0.
        adv(1'b0, 32'hC3);
        for (int i = 0; i < 3; i++) adv(1'b0, 32'h0);
        checks++;
        if (out_tag4 !== 8'hC3 || out_ren4 !== 1'b0) begin
            errors++;
            $display("FAIL tag_without_ren: got tag=%h ren=%b, want c3 0", out_tag4, out_ren4);
        end
    endtask

    task automatic test_stall();
        do_flush();
        adv(1'b1, 32'd1);
        adv(1'b0, 32'd2);
        adv(1'b1, 32'd3);
        adv(1'b1, 32'd4);
        // Stage 0 (newest) .. stage 3 hold ren 1,1,0,1 -> 4'b1011.
        advance = 1'b0;
        for (int c = 0; c < 5; c++) begin
            in_ren = c[0];
            in_tag = 32'hF0 + c;
            step();
            checks++;
            if (sv4 !== 4'b1011 || occ4 !== 3'd3 || out_tag4 !== 8'd1 || out_ren4 !== 1'b1) begin
                errors++;
                $display("FAIL stall_cycle%0d: got sv=%b occ=%0d tag=%h ren=%b, want 1011 3 01 1",
                         c, sv4, occ4, out_tag4, out_ren4);
            end
        end
    endtask

    task automatic test_mode();
        do_flush();
        for (int i = 0; i < 4; i++) adv(1'b1, 32'h20 + i);
        advance = 1'b0;
        mode = 1'b0;
        #1;
        checks++;
        if (res4 !== 1'b1) begin
            errors++;
            $display("FAIL mode_full_or: got %b, want 1", res4);
        end
        mode = 1'b1;
        #1;
        checks++;
        if (res4 !== 1'b1) begin
            errors++;
            $display("FAIL mode_full_and: got %b, want 1", res4);
        end
        mode = 1'b0;
        adv(1'b0, 32'h0);
        advance = 1'b0;
        checks++;
        if (sv4 !== 4'b1110 || res4 !== 1'b1) begin
            errors++;
            $display("FAIL mode_hole_or: got sv=%b res=%b, want 1110 1", sv4, res4);
        end
        mode = 1'b1;
        #1;
        checks++;
        if (res4 !== 1'b0 || sv4 !== 4'b1110) begin
            errors++;
            $display("FAIL mode_hole_and: got sv=%b res=%b, want 1110 0", sv4, res4);
        end
        mode = 1'b0;
    endtask

    task automatic test_flush();
        do_flush();
        for (int i = 0; i < 4; i++) adv(1'b1, 32'h30 + i);
        in_ren  = 1'b1;
        in_tag  = 32'hAB;
        advance = 1'b1;
        flush   = 1'b1;
        step();
        checks++;
        if (sv4 !== 4'b0000 || occ4 !== 3'd0 || out_ren4 !== 1'b0 || out_tag4 !== 8'h00) begin
            errors++;
            $display("FAIL flush_priority: got sv=%b occ=%0d ren=%b tag=%h, want 0000 0 0 00",
                     sv4, occ4, out_ren4, out_tag4);
        end
        flush   = 1'b0;
        advance = 1'b0;
        step();
        checks++;
        if (sv4 !== 4'b0000) begin
            errors++;
            $display("FAIL flush_not_captured: got sv=%b, want 0000", sv4);
        end
    endtask

    task automatic test_sweep();
        do_flush();
        adv(1'b1, 32'hDEADBEEF);
        checks++;
        if (out_ren1 !== 1'b1 || out_tag1 !== 1'b1 || occ1 !== 1'd1 || sv16 !== 16'h0001) begin
            errors++;
            $display("FAIL sweep_edge1: got s1 ren=%b tag=%b occ=%0d, s16 sv=%h, want 1 1 1 0001",
                     out_ren1, out_tag1, occ1, sv16);
        end
        for (int e = 2; e <= 16; e++) begin
            adv(1'b0, 32'h0);
            checks++;
            if (out_ren16 !== (e == 16) || sv16 !== (16'h0001 << (e - 1))) begin
                errors++;
                $display("FAIL sweep16_edge%0d: got ren=%b sv=%h, want ren=%b", e, out_ren16, sv16, (e == 16));
            end
            if (e == 2) begin
                checks++;
                if (out_ren1 !== 1'b0 || out_tag1 !== 1'b0) begin
                    errors++;
                    $display("FAIL sweep1_drop: got ren=%b tag=%b, want 0 0", out_ren1, out_tag1);
                end
            end
        end
        checks++;
        if (out_tag16 !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL sweep16_tag: got %h, want deadbeef", out_tag16);
        end
        for (int i = 0; i < 16; i++) adv(1'b1, i);
        mode = 1'b1;
        #1;
        checks++;
        if (occ16 !== 5'd16 || sv16 !== 16'hFFFF || res16 !== 1'b1 || out_tag16 !== 32'd0) begin
            errors++;
            $display("FAIL sweep16_full: got occ=%0d sv=%h res=%b tag=%h, want 16 ffff 1 0",
                     occ16, sv16, res16, out_tag16);
        end
        mode = 1'b0;
    endtask

    initial begin
        reset   = 1'b1;
        in_ren  = 1'b0;
        in_tag  = '0;
        advance = 1'b0;
        flush   = 1'b0;
        mode    = 1'b0;
        #1;
        test_reset();
        test_latency();
        test_stall();
        test_mode();
        test_flush();
        test_sweep();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
